// File: rtl/activity_counter.sv
// Per-peripheral idle/activity monitor: counts consecutive enabled idle
// cycles (saturating) and holds a recent-activity flag for a fixed window
// after each activity pulse, for clock-gating / power-down policy logic.
//
// Ports:
//   clk             - sole clock, rising edge
//   rst_n           - asynchronous active-low reset
//   activity_pulse  - [N-1:0] per-peripheral activity, sampled every edge
//   periph_en       - [N-1:0] per-peripheral enable (0 clears all state)
//   idle_count      - [N-1:0][W-1:0] registered idle count per peripheral
//   recent_activity - [N-1:0] registered recent-activity flag
//
// Optional: define ACTIVITY_COUNTER_SVA_EN to compile in concurrent
// assertions on counter/flag behaviour. Functionality is unchanged.
module activity_counter #(
  parameter int N               = 4,
  parameter int W               = 16,
  parameter int ACTIVITY_WINDOW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        activity_pulse,
  input  logic [N-1:0]        periph_en,
  output logic [N-1:0][W-1:0] idle_count,
  output logic [N-1:0]        recent_activity
);

  localparam int              WW       = $clog2(ACTIVITY_WINDOW + 1);
  localparam logic [W-1:0]    CNT_MAX  = '1;
  localparam logic [WW-1:0]   WIN_LOAD = WW'(ACTIVITY_WINDOW);

  logic [N-1:0][W-1:0]  idle_counter;
  logic [N-1:0][W-1:0]  idle_counter_d;
  logic [N-1:0][WW-1:0] window_q;
  logic [N-1:0][WW-1:0] window_d;
  logic [N-1:0]         flag_q;
  logic [N-1:0]         flag_d;

  always_comb begin
    idle_counter_d = idle_counter;
    window_d       = window_q;
    flag_d         = flag_q;
    for (int i = 0; i < N; i++) begin
      if (!periph_en[i]) begin
        // Disabled peripherals forget everything; pulses are ignored.
        idle_counter_d[i] = '0;
        window_d[i]       = '0;
        flag_d[i]         = 1'b0;
      end else if (activity_pulse[i]) begin
        idle_counter_d[i] = '0;
        window_d[i]       = WIN_LOAD;
        flag_d[i]         = 1'b1;
      end else begin
        if (idle_counter[i] != CNT_MAX) begin
          idle_counter_d[i] = idle_counter[i] + W'(1);
        end
        // The flag survives the cycle in which the window reaches zero, so
        // it is high for ACTIVITY_WINDOW+1 cycles counting the capture.
        if (window_q[i] != '0) begin
          window_d[i] = window_q[i] - WW'(1);
          flag_d[i]   = 1'b1;
        end else begin
          flag_d[i]   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_counter <= '0;
      window_q     <= '0;
      flag_q       <= '0;
    end else begin
      idle_counter <= idle_counter_d;
      window_q     <= window_d;
      flag_q       <= flag_d;
    end
  end

  assign idle_count      = idle_counter;
  assign recent_activity = flag_q;

`ifdef ACTIVITY_COUNTER_SVA_EN
  for (genvar g = 0; g < N; g++) begin : g_sva
    a_no_decrease: assert property (@(posedge clk) disable iff (!rst_n)
      1'b1 |=> (idle_counter[g] == '0) || (idle_counter[g] >= $past(idle_counter[g])));

    a_zero_after_clear: assert property (@(posedge clk) disable iff (!rst_n)
      (!periph_en[g] || activity_pulse[g]) |=> (idle_counter[g] == '0));

    a_flag_needs_window: assert property (@(posedge clk) disable iff (!rst_n)
      ((window_q[g] == '0) && !(periph_en[g] && activity_pulse[g])) |=> !flag_q[g]);

    a_no_wrap: assert property (@(posedge clk) disable iff (!rst_n)
      ((idle_counter[g] == CNT_MAX) && periph_en[g] && !activity_pulse[g])
        |=> (idle_counter[g] == CNT_MAX));
  end
`endif

endmodule

// File: tb/tb_activity_counter.sv
// Directed bench for activity_counter (N=4, W=16, window 8). Each stimulus
// cycle pushes its expected outputs into a scoreboard queue; a monitor
// pops entries after the corresponding edge and compares.
module tb_activity_counter;

  logic              clk;
  logic              rst_n;
  logic [3:0]        activity_pulse;
  logic [3:0]        periph_en;
  logic [3:0][15:0]  idle_count;
  logic [3:0]        recent_activity;

  activity_counter #(.N(4), .W(16), .ACTIVITY_WINDOW(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .activity_pulse  (activity_pulse),
    .periph_en       (periph_en),
    .idle_count      (idle_count),
    .recent_activity (recent_activity)
  );

  typedef struct {
    int               cyc;
    string            name;
    logic [3:0]       cm;
    logic [3:0][15:0] cnt;
    logic [3:0]       fm;
    logic [3:0]       flg;
  } exp_t;

  exp_t sb_q[$];
  int   cycle_cnt = 0;
  int   chk_cnt   = 0;
  int   pass_cnt  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", nm, cycle_cnt, got, exp);
  endtask

  // Drive inputs for the next edge and record what must be seen after it.
  task automatic step(input string nm, input logic [3:0] en, input logic [3:0] pls,
                      input logic [3:0] cm, input logic [3:0][15:0] cnt,
                      input logic [3:0] fm, input logic [3:0] flg);
    exp_t e;
    periph_en      = en;
    activity_pulse = pls;
    e.cyc  = cycle_cnt + 1;
    e.name = nm;
    e.cm   = cm;
    e.cnt  = cnt;
    e.fm   = fm;
    e.flg  = flg;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare every entry whose edge has already happened.
  initial begin
    exp_t             e;
    logic [3:0][15:0] cmask;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cycle_cnt) begin
        e = sb_q.pop_front();
        for (int i = 0; i < 4; i++) cmask[i] = e.cm[i] ? 16'hFFFF : 16'h0000;
        if (e.cm != 4'b0)
          check({e.name, "_cnt"}, 64'(idle_count & cmask), 64'(e.cnt & cmask));
        if (e.fm != 4'b0)
          check({e.name, "_flag"}, 64'(recent_activity & e.fm), 64'(e.flg & e.fm));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int reached;
    rst_n          = 1'b0;
    periph_en      = 4'hF;
    activity_pulse = 4'h0;
    @(negedge clk);

    // Reset held with all peripherals enabled: nothing may move.
    for (int k = 0; k < 5; k++)
      step("reset", 4'hF, 4'h0, 4'hF, 64'd0, 4'hF, 4'h0);
    rst_n = 1'b1;
    step("post_rst", 4'h0, 4'h0, 4'hF, 64'd0, 4'hF, 4'h0);

    // Enable peripheral 0 only: 1..10.
    for (int k = 1; k <= 10; k++)
      step("en_count", 4'h1, 4'h0, 4'hF, {48'd0, 16'(k)}, 4'hF, 4'h0);

    // Single pulse: flag for capture + 8 edges, low on the 9th.
    step("pulse1", 4'h1, 4'h1, 4'hF, 64'd0, 4'hF, 4'h1);
    for (int k = 1; k <= 9; k++)
      step("win1", 4'h1, 4'h0, 4'h1, {48'd0, 16'(k)}, 4'h1, (k <= 8) ? 4'h1 : 4'h0);

    // Second pulse 3 cycles after the first reloads the window.
    step("pulse2", 4'h1, 4'h1, 4'h1, 64'd0, 4'h1, 4'h1);
    for (int k = 1; k <= 2; k++)
      step("win2", 4'h1, 4'h0, 4'h1, {48'd0, 16'(k)}, 4'h1, 4'h1);
    step("pulse3", 4'h1, 4'h1, 4'h1, 64'd0, 4'h1, 4'h1);
    for (int k = 1; k <= 9; k++)
      step("reload", 4'h1, 4'h0, 4'h1, {48'd0, 16'(k)}, 4'h1, (k <= 8) ? 4'h1 : 4'h0);

    // All enabled, pulse on 0: others start from their enable edge.
    step("all_p0", 4'hF, 4'h1, 4'hF, {16'd1, 16'd1, 16'd1, 16'd0}, 4'hF, 4'h1);
    step("all_c1", 4'hF, 4'h0, 4'hF, {16'd2, 16'd2, 16'd2, 16'd1}, 4'hF, 4'h1);
    step("all_c2", 4'hF, 4'h0, 4'hF, {16'd3, 16'd3, 16'd3, 16'd2}, 4'hF, 4'h1);
    step("all_c3", 4'hF, 4'h0, 4'hF, {16'd4, 16'd4, 16'd4, 16'd3}, 4'hF, 4'h1);
    step("all_p2", 4'hF, 4'h4, 4'hF, {16'd5, 16'd0, 16'd5, 16'd4}, 4'hF, 4'h5);
    step("all_c4", 4'hF, 4'h0, 4'hF, {16'd6, 16'd1, 16'd6, 16'd5}, 4'hF, 4'h5);

    // Saturation: preload near the top, then it must stick at FFFF.
    force dut.idle_counter = {16'd100, 16'd200, 16'hFFFA, 16'd300};
    step("forced", 4'hF, 4'h0, 4'h0, 64'd0, 4'h0, 4'h0);
    release dut.idle_counter;
    reached = 0;
    for (int k = 0; k < 12; k++) begin
      if (idle_count[1] == 16'hFFFF) begin
        reached = 1;
        break;
      end
      step("approach", 4'hF, 4'h0, 4'h0, 64'd0, 4'h0, 4'h0);
    end
    check("sat_reach", 64'(reached), 64'd1);
    for (int k = 0; k < 3; k++)
      step("sat_hold", 4'hF, 4'h0, 4'h2, {16'd0, 16'd0, 16'hFFFF, 16'd0}, 4'h0, 4'h0);

    // Disable mid-count while the flag is up.
    step("dis_p0", 4'hF, 4'h1, 4'h1, 64'd0, 4'h1, 4'h1);
    for (int k = 1; k <= 5; k++)
      step("dis_pre", 4'hF, 4'h0, 4'h1, {48'd0, 16'(k)}, 4'h1, 4'h1);
    step("disable", 4'hE, 4'h0, 4'h1, 64'd0, 4'h1, 4'h0);
    for (int k = 0; k < 5; k++)
      step("dis_pulse", 4'hE, 4'h1, 4'h1, 64'd0, 4'h1, 4'h0);
    step("reenable", 4'hF, 4'h0, 4'h1, {48'd0, 16'd1}, 4'h1, 4'h0);
    step("reen_c2", 4'hF, 4'h0, 4'h1, {48'd0, 16'd2}, 4'h1, 4'h0);

    // Let the monitor drain the scoreboard.
    for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clk);
    check("drain", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/activity_counter.md
# activity_counter

Per-peripheral idle/activity monitor for the power-management subsystem. For each of N peripherals it counts consecutive enabled idle cycles and raises a "recent activity" flag for a fixed window after each activity pulse. Downstream clock-gating and power-down policy logic uses these outputs to decide when a peripheral may be gated.

## Interface
- N, default 4: number of monitored peripherals.
- W, default 16: idle counter width in bits. Each counter saturates at 2^W-1.
- ACTIVITY_WINDOW, default 8: number of cycles recent_activity stays asserted after the capture cycle. Must be ≥1.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- activity_pulse  input  [N-1:0]  per-peripheral activity indication, sampled each rising edge; may be held high for multiple cycles.
- periph_en  input  [N-1:0]  per-peripheral enable.
- idle_count  output  [N-1:0][W-1:0] (packed)  registered idle count per peripheral.
- recent_activity  output  [N-1:0]  registered recent-activity flag per peripheral.

## Operation
- Each peripheral i is fully independent. It has:
  - internal idle counter array idle_counter[i], W bits, which drives idle_count[i] directly;
  - window down-counter, $clog2(ACTIVITY_WINDOW+1) bits;
  - recent-activity flag register.
- Per-edge update, in priority order:
  - periph_en[i]=0: idle_counter←0, window←0, flag←0. activity_pulse[i] is ignored.
  - periph_en[i]=1 and activity_pulse[i]=1: idle_counter←0, window←ACTIVITY_WINDOW, flag←1.
  - periph_en[i]=1, no pulse, idle_counter<2^W-1: idle_counter←idle_counter+1.
  - periph_en[i]=1, no pulse, idle_counter=2^W-1: hold (saturate, never wrap).
  - periph_en[i]=1, no pulse, window≠0: window←window-1, flag stays 1.
  - periph_en[i]=1, no pulse, window=0: flag←0.
- A pulse arriving while the window is active reloads the window to ACTIVITY_WINDOW.
- Simultaneous pulses on several peripherals are all handled in the same cycle.
- Reset (asynchronous, any time): all idle_counter, window and flag registers clear to 0. idle_count='0 and recent_activity='0 immediately.

## Timing
- idle_count and recent_activity are pure register outputs; no combinational path from any input.
- Enable edge E is the first edge at which periph_en=1 is sampled. After E: idle_count=1. After E+k: idle_count=k+1.
- Pulse edge P is the edge at which the pulse is sampled. After P: idle_count=0 and recent_activity=1. After P+k (no further pulses): idle_count=k.
- recent_activity is high after edges P through P+ACTIVITY_WINDOW, i.e. ACTIVITY_WINDOW+1 cycles. It is low after edge P+ACTIVITY_WINDOW+1.
- Disable takes effect at the next edge: count and flag are both 0 after that edge.
- Re-enable restarts counting from 0.

## Configuration
- Macro ACTIVITY_COUNTER_SVA_EN.
- When defined, concurrent assertions are compiled in:
  - idle_count never decreases except to 0;
  - idle_count is 0 the cycle after a pulse or a disable;
  - recent_activity is 0 whenever the window is 0 and no pulse was captured;
  - no counter wraps from 2^W-1 to 0 without a pulse or disable.
- When undefined, no assertion code is present. Functional behaviour is identical either way.

## Test plan
- Reset held 5 cycles, then released: all idle_count=0 and all recent_activity=0.
- periph_en[0]=1, no pulses, 10 cycles: idle_count[0] reads 1,2,…,10 on successive edges.
- Pulse on peripheral 0: idle_count[0]=0 and recent_activity[0]=1. With defaults, the flag stays 1 for 8 more edges and is 0 on the 9th. A second pulse 3 cycles after the first reloads the window: 0 only 9 edges after the second pulse.
- All peripherals enabled, pulse on peripheral 0 only, then 3 cycles: idle_count = {4,4,4,3} for peripherals 3..0. Then pulse on peripheral 2 plus one cycle: peripheral 0 reads 5, peripheral 2 reads 1.
- Force idle_counter[1]=16'hFFFA for one cycle, then release: idle_count[1] reaches 16'hFFFF and holds for at least 2 more cycles.
- Peripheral 0 counting to 5 with recent_activity=1, then periph_en[0]=0: after the next edge, idle_count[0]=0 and recent_activity[0]=0. It remains 0 for 5 more cycles, and pulses are ignored while disabled.
